// File: rtl/conversor_bcd_seq.sv
// Sequential binary-to-BCD display encoder (shift-and-add-3), sign/blank/dash codes per digit.
// Optional macro SUPRIME_ZEROS_EN blanks leading zero digits of the result.
module conversor_bcd_seq #(
  parameter int LARGURA = 16,
  parameter int DIGITOS = 5
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   inicio,
  input  logic [LARGURA-1:0]     numero,
  output logic                   ocupado,
  output logic                   pronto,
  output logic [4*DIGITOS-1:0]   digitos,
  output logic [3:0]             sinal,
  output logic                   estouro
);

  localparam int BCD_W = 4 * DIGITOS;
  localparam int CNT_W = $clog2(LARGURA + 1);
  localparam logic [3:0] COD_TRACO  = 4'd10;
  localparam logic [3:0] COD_BRANCO = 4'd11;

  typedef enum logic [1:0] {OCIOSO, DESLOCA, FINALIZA} estado_t;
  estado_t estado, prox_estado;

  logic signed [LARGURA-1:0] numero_s;
  logic [LARGURA-1:0]        magnitude;
  logic [BCD_W-1:0]          bcd;
  logic [BCD_W:0]            desloc;
  logic [CNT_W-1:0]          contador;
  logic                      negativo;
  logic                      sentinela;
  logic                      ovf;

  // Add-3 correction on every digit that would reach 10 or more after doubling.
  function automatic logic [BCD_W-1:0] corrige(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    r = v;
    for (int k = 0; k < DIGITOS; k++) begin
      if (v[4*k +: 4] >= 4'd5)
        r[4*k +: 4] = v[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  function automatic logic [BCD_W-1:0] preenche(input logic [3:0] codigo);
    return {DIGITOS{codigo}};
  endfunction

`ifdef SUPRIME_ZEROS_EN
  // Blank zeros from the top digit down to the first nonzero; units digit always shown.
  function automatic logic [BCD_W-1:0] suprime(input logic [BCD_W-1:0] v);
    logic [BCD_W-1:0] r;
    logic             apagando;
    r        = v;
    apagando = 1'b1;
    for (int k = DIGITOS - 1; k >= 1; k--) begin
      if (apagando && (v[4*k +: 4] == 4'd0))
        r[4*k +: 4] = COD_BRANCO;
      else
        apagando = 1'b0;
    end
    return r;
  endfunction
`endif

  assign numero_s = numero;
  assign desloc   = {corrige(bcd), magnitude[LARGURA-1]};
  assign ocupado  = (estado != OCIOSO);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) estado <= OCIOSO;
    else       estado <= prox_estado;
  end

  always_comb begin
    prox_estado = estado;
    case (estado)
      OCIOSO:   if (inicio) prox_estado = DESLOCA;
      DESLOCA:  if (contador == CNT_W'(1)) prox_estado = FINALIZA;
      FINALIZA: prox_estado = OCIOSO;
      default:  prox_estado = OCIOSO;
    endcase
  end

  // Stage boundary: operand capture, serial shift, and registered result update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      magnitude <= '0;
      bcd       <= '0;
      contador  <= '0;
      negativo  <= 1'b0;
      sentinela <= 1'b0;
      ovf       <= 1'b0;
      pronto    <= 1'b0;
      digitos   <= preenche(COD_BRANCO);
      sinal     <= COD_BRANCO;
      estouro   <= 1'b0;
    end else begin
      pronto <= 1'b0;
      case (estado)
        OCIOSO: begin
          if (inicio) begin
            negativo  <= numero[LARGURA-1];
            sentinela <= &numero;
            magnitude <= (numero_s < 0) ? $unsigned(-numero_s) : numero;
            bcd       <= '0;
            ovf       <= 1'b0;
            contador  <= CNT_W'(LARGURA);
          end
        end
        DESLOCA: begin
          bcd       <= desloc[BCD_W-1:0];
          magnitude <= magnitude << 1;
          contador  <= contador - CNT_W'(1);
          if (desloc[BCD_W]) ovf <= 1'b1;
        end
        FINALIZA: begin
          pronto <= 1'b1;
          if (sentinela) begin
            digitos <= preenche(COD_BRANCO);
            sinal   <= COD_BRANCO;
            estouro <= 1'b0;
          end else begin
            sinal   <= negativo ? COD_TRACO : COD_BRANCO;
            estouro <= ovf;
            if (ovf)
              digitos <= preenche(COD_TRACO);
            else
`ifdef SUPRIME_ZEROS_EN
              digitos <= suprime(bcd);
`else
              digitos <= bcd;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_bcd_seq.sv
// Scoreboard bench: stimulus pushes hand-computed results, monitors pop and compare on pronto.
module tb_conversor_bcd_seq;

  localparam int LARGURA = 16;

  typedef struct {
    logic [19:0] dig;
    logic [3:0]  sin;
    logic        est;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic inicio5, inicio4;
  logic [15:0] numero5, numero4;
  logic ocupado5, pronto5, estouro5;
  logic ocupado4, pronto4, estouro4;
  logic [19:0] digitos5;
  logic [15:0] digitos4;
  logic [3:0] sinal5, sinal4;

  int cyc = 0;
  int nvec = 0;
  int nfail = 0;
  exp_t q5[$];
  exp_t q4[$];
  logic [19:0] last5;

  conversor_bcd_seq #(.LARGURA(16), .DIGITOS(5)) dut5 (
    .clock(clk), .reset(reset), .inicio(inicio5), .numero(numero5),
    .ocupado(ocupado5), .pronto(pronto5), .digitos(digitos5),
    .sinal(sinal5), .estouro(estouro5));

  conversor_bcd_seq #(.LARGURA(16), .DIGITOS(4)) dut4 (
    .clock(clk), .reset(reset), .inicio(inicio4), .numero(numero4),
    .ocupado(ocupado4), .pronto(pronto4), .digitos(digitos4),
    .sinal(sinal4), .estouro(estouro4));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    nvec++;
    if (act !== req) begin
      nfail++;
      $display("FAIL %s: got %h, required %h (t=%0t)", nm, act, req, $time);
    end
  endtask

  function automatic logic [19:0] blank_lead(input logic [19:0] v, input int n);
    logic [19:0] r;
    logic        on;
    r  = v;
    on = 1'b1;
    for (int k = n - 1; k >= 1; k--) begin
      if (on && v[4*k +: 4] == 4'd0) r[4*k +: 4] = 4'hB;
      else on = 1'b0;
    end
    return r;
  endfunction

  // Called at posedge+#1; inicio is sampled on the next edge, pronto rises LARGURA+1 edges after that.
  task automatic start(input bit sel4, input logic [15:0] v, input bit expect_it,
                       input logic [19:0] dig, input logic [3:0] sin, input logic est);
    exp_t e;
    e.dig = dig;
    e.sin = sin;
    e.est = est;
    e.due = cyc + LARGURA + 2;
`ifdef SUPRIME_ZEROS_EN
    e.dig = blank_lead(dig, sel4 ? 4 : 5);
`endif
    if (sel4) begin inicio4 = 1'b1; numero4 = v; end
    else      begin inicio5 = 1'b1; numero5 = v; end
    if (expect_it) begin
      if (sel4) q4.push_back(e);
      else      q5.push_back(e);
    end
    @(posedge clk); #1;
    inicio4 = 1'b0;
    inicio5 = 1'b0;
  endtask

  task automatic wait_idle(input bit sel4, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!(sel4 ? ocupado4 : ocupado5)) return;
    end
    chk(sel4 ? "timeout_dut4" : "timeout_dut5", 64'd1, 64'd0);
  endtask

  task automatic run5(input logic [15:0] v, input logic [19:0] dig, input logic [3:0] sin);
    start(1'b0, v, 1'b1, dig, sin, 1'b0);
    last5 = dig;
`ifdef SUPRIME_ZEROS_EN
    last5 = blank_lead(dig, 5);
`endif
    wait_idle(1'b0, 40);
  endtask

  task automatic run4(input logic [15:0] v, input logic [15:0] dig, input logic [3:0] sin,
                      input logic est);
    start(1'b1, v, 1'b1, {4'h0, dig}, sin, est);
    wait_idle(1'b1, 40);
  endtask

  always @(negedge clk) begin
    if (!reset && pronto5) begin
      if (q5.size() == 0) begin
        chk("unexpected_pronto_dut5", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q5.pop_front();
        chk("digitos_dut5", digitos5, e.dig);
        chk("sinal_dut5", sinal5, e.sin);
        chk("estouro_dut5", estouro5, e.est);
        chk("latency_dut5", cyc, e.due);
      end
    end
  end

  always @(negedge clk) begin
    if (!reset && pronto4) begin
      if (q4.size() == 0) begin
        chk("unexpected_pronto_dut4", 64'd1, 64'd0);
      end else begin
        exp_t e;
        e = q4.pop_front();
        chk("digitos_dut4", digitos4, e.dig[15:0]);
        chk("sinal_dut4", sinal4, e.sin);
        chk("estouro_dut4", estouro4, e.est);
        chk("latency_dut4", cyc, e.due);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, required finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1; inicio5 = 1'b0; inicio4 = 1'b0; numero5 = '0; numero4 = '0; last5 = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ocupado5", ocupado5, 1'b0);
    chk("rst_pronto5", pronto5, 1'b0);
    chk("rst_digitos5", digitos5, 20'hBBBBB);
    chk("rst_sinal5", sinal5, 4'hB);
    chk("rst_estouro5", estouro5, 1'b0);
    chk("rst_digitos4", digitos4, 16'hBBBB);
    chk("rst_ocupado4", ocupado4, 1'b0);
    reset = 1'b0;

    // First conversion starts on the very first edge after reset release; the rest run back-to-back.
    run5(16'd1234,  20'h01234, 4'hB);
    run5(16'h8000,  20'h32768, 4'hA);
    run5(16'hFFFF,  20'hBBBBB, 4'hB);
    run5(16'hFFFE,  20'h00002, 4'hA);
    run5(16'd0,     20'h00000, 4'hB);
    run5(16'h7FFF,  20'h32767, 4'hB);
    run5(16'hFC18,  20'h01000, 4'hA);
    run5(16'hC350,  20'h15536, 4'hA);
    run5(16'd9,     20'h00009, 4'hB);

    // Start request with a different operand while busy must be ignored.
    start(1'b0, 16'd1234, 1'b1, 20'h01234, 4'hB, 1'b0);
    last5 = 20'h01234;
`ifdef SUPRIME_ZEROS_EN
    last5 = blank_lead(20'h01234, 5);
`endif
    repeat (4) @(posedge clk);
    #1;
    inicio5 = 1'b1; numero5 = 16'd7;
    @(posedge clk); #1;
    inicio5 = 1'b0;
    wait_idle(1'b0, 40);

    repeat (6) @(posedge clk);
    #1;
    chk("hold_digitos5", digitos5, last5);
    chk("hold_ocupado5", ocupado5, 1'b0);

    run4(16'd12345, 16'hAAAA, 4'hB, 1'b1);
    run4(16'd9999,  16'h9999, 4'hB, 1'b0);
    run4(16'hCFC7,  16'hAAAA, 4'hA, 1'b1);
    run4(16'd10000, 16'hAAAA, 4'hB, 1'b1);
    run4(16'd0,     16'h0000, 4'hB, 1'b0);

    // Abort mid-shift: outputs blank at once, no pronto for the aborted operand.
    start(1'b0, 16'd4321, 1'b0, 20'h0, 4'h0, 1'b0);
    repeat (4) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_ocupado5", ocupado5, 1'b0);
    chk("abort_pronto5", pronto5, 1'b0);
    chk("abort_digitos5", digitos5, 20'hBBBBB);
    chk("abort_sinal5", sinal5, 4'hB);
    chk("abort_estouro5", estouro5, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    run5(16'd42, 20'h00042, 4'hB);

    repeat (25) @(posedge clk);
    #1;
    chk("queue5_drained", q5.size(), 0);
    chk("queue4_drained", q4.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
